// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants for the operand fetch stage and its register file.
package operand_fetch_stage_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int ZERO_REG       = 0;
   localparam int REG_COUNT      = 2 ** DEF_ADDR_WIDTH;

   // True when a write-back targets a real register and matches the read address.
   function automatic logic wr_hits(input logic       wr_en,
                                    input logic [31:0] wr_addr,
                                    input logic [31:0] rd_addr);
      return wr_en && (wr_addr != 32'(ZERO_REG)) && (wr_addr == rd_addr);
   endfunction

endpackage

// File: rtl/operand_fetch_stage_regfile.sv
// Two-read, one-write register file: register 0 is hardwired to zero and
// reads see a same-cycle write-back through a combinational bypass.
module regfile_2r1w
   import operand_fetch_stage_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_WIDTH-1:0] i_rd0_addr,
   output logic [DATA_WIDTH-1:0] o_rd0_data,
   input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
   output logic [DATA_WIDTH-1:0] o_rd1_data,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Storage update; entry 0 is never written so it stays zero after reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en && (i_wr_addr != ZERO_ADDR)) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end else begin
         r_mem[i_wr_addr] <= r_mem[i_wr_addr];
      end
   end

   // Read port 0 with zero-register rule and write-through bypass.
   always_comb begin
      o_rd0_data = '0;
      if (i_rd0_addr == ZERO_ADDR) begin
         o_rd0_data = '0;
      end else if (wr_hits(i_wr_en, 32'(i_wr_addr), 32'(i_rd0_addr))) begin
         o_rd0_data = i_wr_data;
      end else begin
         o_rd0_data = r_mem[i_rd0_addr];
      end
   end

   // Read port 1, identical rules, independent of port 0.
   always_comb begin
      o_rd1_data = '0;
      if (i_rd1_addr == ZERO_ADDR) begin
         o_rd1_data = '0;
      end else if (wr_hits(i_wr_en, 32'(i_wr_addr), 32'(i_rd1_addr))) begin
         o_rd1_data = i_wr_data;
      end else begin
         o_rd1_data = r_mem[i_rd1_addr];
      end
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads two operands from the register file and holds
// them in an output register handed to the ALU under valid/ready.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b
);

   logic [DATA_WIDTH-1:0] w_rs_data;
   logic [DATA_WIDTH-1:0] w_rt_data;
   logic                  w_accept;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_a;
   logic [DATA_WIDTH-1:0] r_out_b;

   regfile_2r1w #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_regfile (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_rd0_addr (rs_addr),
      .o_rd0_data (w_rs_data),
      .i_rd1_addr (rt_addr),
      .o_rd1_data (w_rt_data),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data)
   );

   // Ready whenever the output slot is empty or being drained this cycle.
   always_comb begin
      in_ready = (!r_out_valid) || out_ready;
      w_accept = in_valid && in_ready;
   end

   // Output register: capture on accept, clear valid on drain, else hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_a     <= '0;
         r_out_b     <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_a     <= w_rs_data;
         r_out_b     <= w_rt_data;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
         r_out_a     <= r_out_a;
         r_out_b     <= r_out_b;
      end else begin
         r_out_valid <= r_out_valid;
         r_out_a     <= r_out_a;
         r_out_b     <= r_out_b;
      end
   end

   assign out_valid = r_out_valid;
   assign out_a     = r_out_a;
   assign out_b     = r_out_b;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus a
// randomized run compared against a behavioural register-file model.
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_rf [32];
   logic        m_valid;
   logic [31:0] m_a;
   logic [31:0] m_b;

   operand_fetch_stage dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_read(input logic [4:0] addr);
      if (addr == 5'd0) return 32'd0;
      if (wr_en && wr_addr == addr) return wr_data;
      return m_rf[addr];
   endfunction

   task automatic model_edge();
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rdy;
      ra  = model_read(rs_addr);
      rb  = model_read(rt_addr);
      rdy = !m_valid || out_ready;
      if (reset) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
         m_valid = 1'b0;
         m_a     = 32'd0;
         m_b     = 32'd0;
      end else begin
         if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_a     = ra;
            m_b     = rb;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         if (wr_en && wr_addr != 5'd0) m_rf[wr_addr] = wr_data;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      reset     = 1'b0;
      in_valid  = 1'b0;
      rs_addr   = 5'd0;
      rt_addr   = 5'd0;
      wr_en     = 1'b0;
      wr_addr   = 5'd0;
      wr_data   = 32'd0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: valid=%b a=%h b=%h required 0/0/0", out_valid, out_a, out_b);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      in_valid = 1'b1; rs_addr = 5'd3; rt_addr = 5'd7;
      cycle();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_a !== 32'd0 || out_b !== 32'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL first_read: valid=%b a=%h b=%h rdy=%b required 1/0/0/1", out_valid, out_a, out_b, in_ready);
      end
   endtask

   task automatic test_or_operands();
      logic [31:0] ored;
      wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h0F0F0000;
      cycle();
      wr_addr = 5'd2; wr_data = 32'h3C222A81;
      cycle();
      wr_en = 1'b0;
      in_valid = 1'b1; rs_addr = 5'd1; rt_addr = 5'd2;
      cycle();
      in_valid = 1'b0;
      ored = out_a | out_b;
      checks++;
      if (out_a !== 32'h0F0F0000 || out_b !== 32'h3C222A81) begin
         failures++;
         $display("FAIL or_operands: a=%h b=%h required 0f0f0000/3c222a81", out_a, out_b);
      end
      checks++;
      if (ored !== 32'h3F2F2A81) begin
         failures++;
         $display("FAIL or_result: got %h required 3f2f2a81", ored);
      end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      in_valid = 1'b1; rs_addr = 5'd5; rt_addr = 5'd5;
      cycle();
      wr_en = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_a !== 32'hDEADBEEF || out_b !== 32'hDEADBEEF || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bypass: a=%h b=%h v=%b required deadbeef/deadbeef/1", out_a, out_b, out_valid);
      end
   endtask

   task automatic test_zero_reg();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      in_valid = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0;
      cycle();
      checks++;
      if (out_a !== 32'd0) begin
         failures++;
         $display("FAIL zero_bypass: a=%h required 0", out_a);
      end
      wr_en = 1'b0;
      cycle();
      in_valid = 1'b0;
      checks++;
      if (out_a !== 32'd0 || out_b !== 32'd0) begin
         failures++;
         $display("FAIL zero_read: a=%h b=%h required 0/0", out_a, out_b);
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      in_valid = 1'b1; rs_addr = 5'd1; rt_addr = 5'd2;
      cycle();
      out_ready = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h12345678;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL stall_in_ready: got %b required 0", in_ready);
      end
      cycle();
      wr_en = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_a !== 32'h0F0F0000 || out_b !== 32'h3C222A81) begin
         failures++;
         $display("FAIL stall_hold: v=%b a=%h b=%h required 1/0f0f0000/3c222a81", out_valid, out_a, out_b);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_in_ready: got %b required 1", in_ready);
      end
      cycle();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_a !== 32'h12345678) begin
         failures++;
         $display("FAIL after_stall: v=%b a=%h required 1/12345678", out_valid, out_a);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b0 || out_a !== 32'h12345678) begin
         failures++;
         $display("FAIL drain: v=%b a=%h required 0/12345678", out_valid, out_a);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; rs_addr = 5'd2; rt_addr = 5'd1;
      cycle();
      in_valid = 1'b0;
      reset = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5A5A5A5;
      cycle();
      reset = 1'b0; wr_en = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_a !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid: v=%b a=%h required 0/0", out_valid, out_a);
      end
      out_ready = 1'b1;
      in_valid = 1'b1; rs_addr = 5'd4; rt_addr = 5'd1;
      cycle();
      in_valid = 1'b0;
      checks++;
      if (out_a !== 32'd0 || out_b !== 32'd0) begin
         failures++;
         $display("FAIL reset_clears_rf: a=%h b=%h required 0/0", out_a, out_b);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset     = ($urandom_range(0, 99) == 0);
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         rs_addr   = 5'($urandom_range(0, 7));
         rt_addr   = 5'($urandom_range(0, 7));
         wr_en     = $urandom_range(0, 1) != 0;
         wr_addr   = 5'($urandom_range(0, 7));
         wr_data   = $urandom;
         #1;
         checks++;
         if (in_ready !== (!m_valid || out_ready)) begin
            failures++;
            $display("FAIL rand_in_ready[%0d]: got %b required %b", n, in_ready, !m_valid || out_ready);
         end
         cycle();
         checks++;
         if (out_valid !== m_valid || out_a !== m_a || out_b !== m_b) begin
            failures++;
            $display("FAIL rand_out[%0d]: v=%b a=%h b=%h required %b/%h/%h", n, out_valid, out_a, out_b, m_valid, m_a, m_b);
         end
      end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_valid = 1'b0;
      m_a     = 32'd0;
      m_b     = 32'd0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_or_operands();
      test_bypass();
      test_zero_reg();
      test_stall();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Supplies the two 32-bit operands a and b to the ALU bitwise units (Or, And, etc.) that sit directly downstream.
- Holds a 32-entry general register file with 2 read ports and 1 write port.
- Captures both operands into an output pipeline register.
- Transfers to the ALU with a valid/ready handshake, so the ALU side can stall the stage.

Parameters:
- DATA_WIDTH, 32, width of each register and operand.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents rs_addr/rt_addr this cycle.
- in_ready  output  1  stage accepts a request this cycle.
- rs_addr  input  ADDR_WIDTH  source register for operand a.
- rt_addr  input  ADDR_WIDTH  source register for operand b.
- wr_en  input  1  write-back enable.
- wr_addr  input  ADDR_WIDTH  write-back destination.
- wr_data  input  DATA_WIDTH  write-back data.
- out_valid  output  1  out_a/out_b hold a valid operand pair.
- out_ready  input  1  ALU consumes the pair this cycle.
- out_a  output  DATA_WIDTH  operand a to the ALU.
- out_b  output  DATA_WIDTH  operand b to the ALU.

Behaviour:
- Reset (synchronous, active-high):
  - All register-file entries become 0.
  - out_valid becomes 0; out_a and out_b become 0.
  - A wr_en in the same cycle is ignored; reset wins.
  - A request held in the output register is discarded.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are ignored.
- Write port:
  - On the edge where wr_en=1 and wr_addr!=0, entry[wr_addr] <= wr_data.
- Read with write-through bypass (combinational read):
  - If wr_en=1, wr_addr!=0 and wr_addr equals the read address, the read returns wr_data, not the old entry.
  - This applies per port independently.
  - If rs_addr==rt_addr, both ports return the same value.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no skid buffer).
  - Accept when in_valid && in_ready. On that edge: out_a <= read(rs_addr), out_b <= read(rt_addr), out_valid <= 1.
  - Latency is 1 cycle: a request accepted at edge N is visible after edge N.
  - If out_valid && out_ready && !in_valid: out_valid <= 0; out_a/out_b keep their last values.
  - If out_valid && !out_ready: out_a, out_b and out_valid stay stable, and in_ready=0.
- Full throughput: back-to-back accepts, one per cycle, while out_ready=1.
- Stale-data rule: operands are captured at accept time. A later write to a source register does not update a pair already held in the output register. The upstream hazard unit owns that case.
- No X propagation: the output register is always reset and is never loaded from an undefined address. Addresses are full-range, so every address is defined.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - ZERO_REG = 0.
  - REG_COUNT = 2**ADDR_WIDTH.
- Sub-module regfile_2r1w:
  - Storage, zero-register rule and write-through bypass.
  - Ports: clk, reset, 2 read address/data pairs, 1 write port.
- The top level adds only the handshake logic and the output register.

Test Plan:
- Reset, then request rs=3, rt=7 with out_ready=1 -> after 1 cycle out_valid=1, out_a=0, out_b=0; in_ready=1 throughout.
- Write r1=32'h0F0F0000 and r2=32'h3C222A81, then request rs=1, rt=2 -> out_a=32'h0F0F0000, out_b=32'h3C222A81; the downstream Or produces 32'h3F2F2A81.
- Same-cycle write r5=32'hDEADBEEF with a request rs=5, rt=5 -> next cycle out_a=out_b=32'hDEADBEEF (bypass).
- Write r0=32'hFFFFFFFF, then request rs=0 -> out_a=0.
- Hold out_ready=0 after an accept of r1/r2, write r1=32'h12345678 and present a new request -> in_ready=0; out_a stays 32'h0F0F0000 until out_ready=1. The next accept then returns 32'h12345678.
- Assert reset while out_valid=1 and wr_en=1 writes r4=32'hA5A5A5A5 -> next cycle out_valid=0; a later read of r4 returns 0.
